regfile_wb_sched: RTL and testbench

// - Writeback scheduler for the 32x32 MIPS register file. The register file has one write port.
// - Arbitrates that port between two producers: ALU result and memory-load result.
// - Drives a registered write command with byte enables for byte/halfword loads (LBU/LHU).
// - Keeps a pending-write scoreboard so decode can stall on RAW hazards against rs/rt.

---
 rtl/regfile_pkg.sv | 33 +++
 rtl/rr_arb2.sv | 39 +++
 rtl/regfile_wb_sched.sv | 125 ++++++++++++
 tb/tb_regfile_wb_sched.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared definitions for the register-file writeback path: write-size codes,
// the byte-enable masks they decode to, and the arbiter grant encoding.
package regfile_pkg;

  // Write-size codes carried alongside each writeback request
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  // Byte enables presented to the register file, low byte is lane 0
  localparam logic [3:0] MASK_BYTE = 4'b0001;
  localparam logic [3:0] MASK_HALF = 4'b0011;
  localparam logic [3:0] MASK_WORD = 4'b1111;

  // Which producer owned the write port most recently
  typedef enum logic {
    GNT_ALU = 1'b0,
    GNT_MEM = 1'b1
  } grant_e;

  // The unused size code 2'b11 is treated as a full word so a stray encoding
  // never produces a partial write.
  function automatic logic [3:0] size_to_mask(input logic [1:0] size);
    logic [3:0] mask;
    case (size)
      SZ_BYTE: mask = MASK_BYTE;
      SZ_HALF: mask = MASK_HALF;
      default: mask = MASK_WORD;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-request round-robin arbiter. On contention the source that did not win
// last time is granted; a lone requester always wins. Grants are combinational
// from the requests and the stored last grant, and are forced low in reset.
module rr_arb2
  import regfile_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic req_alu_i,
  input  logic req_mem_i,
  output logic gnt_alu_o,
  output logic gnt_mem_o
);

  grant_e last_q;
  grant_e last_d;

  // Pick a winner and work out who becomes the new last grant
  always_comb begin
    gnt_alu_o = rst_n & req_alu_i & (~req_mem_i | (last_q == GNT_MEM));
    gnt_mem_o = rst_n & req_mem_i & (~req_alu_i | (last_q == GNT_ALU));
    last_d    = last_q;
    if (gnt_alu_o) begin
      last_d = GNT_ALU;
    end else if (gnt_mem_o) begin
      last_d = GNT_MEM;
    end
  end

  // Remember the last winner; reset favours the ALU on the first contention
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= GNT_MEM;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/regfile_wb_sched.sv
// Writeback scheduler for the single write port of the MIPS register file.
// ALU and load results compete through a round-robin arbiter; the winner is
// registered into a write command one cycle later. A pending-write scoreboard
// lets decode stall on RAW hazards and refuse a second producer per register.
module regfile_wb_sched
  import regfile_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_REGS = 2 ** ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [ADDR_W-1:0] alu_rd,
  input  logic [DATA_W-1:0] alu_data,
  input  logic [1:0]        alu_size,
  input  logic              mem_valid,
  output logic              mem_ready,
  input  logic [ADDR_W-1:0] mem_rd,
  input  logic [DATA_W-1:0] mem_data,
  input  logic [1:0]        mem_size,
  input  logic              issue_alloc,
  input  logic [ADDR_W-1:0] issue_rd,
  output logic              alloc_ok,
  input  logic [ADDR_W-1:0] issue_rs,
  input  logic [ADDR_W-1:0] issue_rt,
  output logic              rs_busy,
  output logic              rt_busy,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic [3:0]        rf_wmask
);

  logic              gnt_alu;
  logic              gnt_mem;
  logic              grant;
  logic [ADDR_W-1:0] sel_rd;
  logic [DATA_W-1:0] sel_data;
  logic [1:0]        sel_size;

  logic              rf_we_q;
  logic              rf_we_d;
  logic [ADDR_W-1:0] rf_waddr_q;
  logic [DATA_W-1:0] rf_wdata_q;
  logic [3:0]        rf_wmask_q;

  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] busy_d;

  rr_arb2 u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_alu_i (alu_valid),
    .req_mem_i (mem_valid),
    .gnt_alu_o (gnt_alu),
    .gnt_mem_o (gnt_mem)
  );

  assign alu_ready = gnt_alu;
  assign mem_ready = gnt_mem;
  assign grant     = gnt_alu | gnt_mem;

  // Steer the granted request onto the write path; writes to $zero are dropped
  always_comb begin
    sel_rd   = alu_rd;
    sel_data = alu_data;
    sel_size = alu_size;
    if (gnt_mem) begin
      sel_rd   = mem_rd;
      sel_data = mem_data;
      sel_size = mem_size;
    end
    rf_we_d = grant & (sel_rd != '0);
  end

  // Register the write command; address/data/mask hold when nothing is granted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      rf_wmask_q <= '0;
    end else begin
      rf_we_q <= rf_we_d;
      if (grant) begin
        rf_waddr_q <= sel_rd;
        rf_wdata_q <= sel_data;
        rf_wmask_q <= size_to_mask(sel_size);
      end
    end
  end

  assign rf_we    = rf_we_q;
  assign rf_waddr = rf_waddr_q;
  assign rf_wdata = rf_wdata_q;
  assign rf_wmask = rf_wmask_q;

  // Decode sees the current busy bits; grant clears, allocation sets and wins
  always_comb begin
    alloc_ok = ~busy_q[issue_rd];
    rs_busy  = busy_q[issue_rs];
    rt_busy  = busy_q[issue_rt];
    busy_d   = busy_q;
    if (grant) begin
      busy_d[sel_rd] = 1'b0;
    end
    if (issue_alloc && alloc_ok && (issue_rd != '0)) begin
      busy_d[issue_rd] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  // Pending-write scoreboard state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

endmodule

// File: tb/tb_regfile_wb_sched.sv
// Self-checking bench for regfile_wb_sched. A small reference model predicts
// grants, write commands and scoreboard state; predicted writes are queued when
// stimulus is applied and popped when the registered command appears.
module tb_regfile_wb_sched;

  logic        clk;
  logic        rst_n;
  logic        alu_valid, alu_ready, mem_valid, mem_ready;
  logic [4:0]  alu_rd, mem_rd, issue_rd, issue_rs, issue_rt, rf_waddr;
  logic [31:0] alu_data, mem_data, rf_wdata;
  logic [1:0]  alu_size, mem_size;
  logic        issue_alloc, alloc_ok, rs_busy, rt_busy, rf_we;
  logic [3:0]  rf_wmask;

  typedef struct packed {
    logic        we;
    logic [4:0]  addr;
    logic [31:0] data;
    logic [3:0]  mask;
    logic        chk;
  } exp_t;

  exp_t expQ[$];
  exp_t e;

  int errors = 0;
  int checks = 0;

  // Reference model state
  logic        lastGrantM;
  logic [31:0] busyM;
  logic [4:0]  holdAddr;
  logic [31:0] holdData;
  logic [3:0]  holdMask;
  logic        holdValid;

  // Observed and predicted values around each applied cycle
  logic obsAluReady, obsMemReady, obsAllocOk;
  logic expAluReady, expMemReady, expAllocOk;

  regfile_wb_sched dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .alu_valid   (alu_valid),
    .alu_ready   (alu_ready),
    .alu_rd      (alu_rd),
    .alu_data    (alu_data),
    .alu_size    (alu_size),
    .mem_valid   (mem_valid),
    .mem_ready   (mem_ready),
    .mem_rd      (mem_rd),
    .mem_data    (mem_data),
    .mem_size    (mem_size),
    .issue_alloc (issue_alloc),
    .issue_rd    (issue_rd),
    .alloc_ok    (alloc_ok),
    .issue_rs    (issue_rs),
    .issue_rt    (issue_rt),
    .rs_busy     (rs_busy),
    .rt_busy     (rt_busy),
    .rf_we       (rf_we),
    .rf_waddr    (rf_waddr),
    .rf_wdata    (rf_wdata),
    .rf_wmask    (rf_wmask)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [3:0] maskOf(input logic [1:0] s);
    if (s == 2'b00) return 4'b0001;
    if (s == 2'b01) return 4'b0011;
    return 4'b1111;
  endfunction

  task automatic modelReset();
    lastGrantM = 1'b1;
    busyM      = '0;
    holdAddr   = '0;
    holdData   = '0;
    holdMask   = '0;
    holdValid  = 1'b1;
    expQ.delete();
  endtask

  // Drive one cycle of requests, predict its outcome, clock it, return at edge+1
  task automatic applyStimulus(input logic aV, input logic [4:0] aRd, input logic [31:0] aD,
                               input logic [1:0] aS, input logic mV, input logic [4:0] mRd,
                               input logic [31:0] mD, input logic [1:0] mS,
                               input logic alloc, input logic [4:0] allocRd);
    logic gA, gM;
    logic [4:0]  rd;
    logic [31:0] nb;
    exp_t x;
    alu_valid = aV;  alu_rd = aRd;  alu_data = aD;  alu_size = aS;
    mem_valid = mV;  mem_rd = mRd;  mem_data = mD;  mem_size = mS;
    issue_alloc = alloc;  issue_rd = allocRd;
    #1;
    obsAluReady = alu_ready;
    obsMemReady = mem_ready;
    obsAllocOk  = alloc_ok;
    gA = aV && (!mV || lastGrantM == 1'b1);
    gM = mV && (!aV || lastGrantM == 1'b0);
    expAluReady = gA;
    expMemReady = gM;
    expAllocOk  = !busyM[allocRd];
    rd = gM ? mRd : aRd;
    x.we = (gA || gM) && (rd != 5'd0);
    if (x.we) begin
      holdAddr  = rd;
      holdData  = gM ? mD : aD;
      holdMask  = maskOf(gM ? mS : aS);
      holdValid = 1'b1;
    end else if (gA || gM) begin
      holdValid = 1'b0;
    end
    x.addr = holdAddr;  x.data = holdData;  x.mask = holdMask;  x.chk = holdValid;
    expQ.push_back(x);
    nb = busyM;
    if (gA || gM) nb[rd] = 1'b0;
    if (alloc && !busyM[allocRd] && allocRd != 5'd0) nb[allocRd] = 1'b1;
    nb[0] = 1'b0;
    if (gA) lastGrantM = 1'b0;
    if (gM) lastGrantM = 1'b1;
    @(posedge clk);
    #1;
    busyM = nb;
  endtask

  task automatic idleCycle();
    applyStimulus(0, 5'd0, 32'd0, 2'b00, 0, 5'd0, 32'd0, 2'b00, 0, 5'd0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'h11; alu_size = 2'b10;
    mem_valid = 1'b1; mem_rd = 5'd2; mem_data = 32'h22; mem_size = 2'b10;
    issue_alloc = 1'b1; issue_rd = 5'd5; issue_rs = 5'd5; issue_rt = 5'd2;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (alu_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_alu_ready got %b want 0", alu_ready); end
    checks++; if (mem_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_mem_ready got %b want 0", mem_ready); end
    checks++; if (rf_we !== 1'b0) begin errors++; $display("[TB] FAIL reset_rf_we got %b want 0", rf_we); end
    checks++; if ({rf_waddr, rf_wdata, rf_wmask} !== 41'd0) begin errors++; $display("[TB] FAIL reset_cmd got %h/%h/%h want 0", rf_waddr, rf_wdata, rf_wmask); end
    checks++; if (rs_busy !== 1'b0 || rt_busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got rs=%b rt=%b want 0", rs_busy, rt_busy); end
    rst_n = 1'b1;
    modelReset();
    applyStimulus(1, 5'd1, 32'h11, 2'b10, 1, 5'd2, 32'h22, 2'b10, 0, 5'd0);
    checks++; if (obsAluReady !== 1'b1 || obsMemReady !== 1'b0) begin errors++; $display("[TB] FAIL first_grant got alu=%b mem=%b want alu=1 mem=0", obsAluReady, obsMemReady); end
    e = expQ.pop_front();
    checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd1 || rf_wdata !== 32'h11) begin errors++; $display("[TB] FAIL first_write got we=%b addr=%0d data=%h want we=1 addr=1 data=11", rf_we, rf_waddr, rf_wdata); end
  endtask

  task automatic test_alternation();
    logic wantAlu;
    // A lone MEM grant makes the ALU the favoured side for the contention run
    applyStimulus(0, 5'd0, 32'd0, 2'b00, 1, 5'd4, 32'h40, 2'b10, 0, 5'd0);
    e = expQ.pop_front();
    checks++; if (rf_we !== e.we || rf_waddr !== e.addr) begin errors++; $display("[TB] FAIL alt_prime got we=%b addr=%0d want we=%b addr=%0d", rf_we, rf_waddr, e.we, e.addr); end
    for (int i = 0; i < 4; i++) begin
      wantAlu = (i % 2 == 0);
      applyStimulus(1, 5'd3, 32'h300 + i, 2'b10, 1, 5'd4, 32'h400 + i, 2'b10, 0, 5'd0);
      checks++; if (obsAluReady !== wantAlu || obsMemReady !== !wantAlu) begin errors++; $display("[TB] FAIL alt_grant%0d got alu=%b mem=%b want alu=%b", i, obsAluReady, obsMemReady, wantAlu); end
      e = expQ.pop_front();
      checks++; if (rf_we !== 1'b1 || rf_waddr !== (wantAlu ? 5'd3 : 5'd4) || rf_wdata !== e.data) begin errors++; $display("[TB] FAIL alt_write%0d got we=%b addr=%0d data=%h want addr=%0d data=%h", i, rf_we, rf_waddr, rf_wdata, wantAlu ? 3 : 4, e.data); end
    end
  endtask

  task automatic test_byte_enables();
    logic [1:0]  sz[4]  = '{2'b00, 2'b01, 2'b11, 2'b10};
    logic [31:0] dat[4] = '{32'h000000AB, 32'h1234ABCD, 32'hCAFEF00D, 32'h0BADBEEF};
    logic [3:0]  msk[4] = '{4'b0001, 4'b0011, 4'b1111, 4'b1111};
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 5'd0, 32'd0, 2'b00, 1, 5'd9, dat[i], sz[i], 0, 5'd0);
      e = expQ.pop_front();
      checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd9 || rf_wdata !== dat[i] || rf_wmask !== msk[i]) begin errors++; $display("[TB] FAIL bytes%0d got we=%b addr=%0d data=%h mask=%b want addr=9 data=%h mask=%b", i, rf_we, rf_waddr, rf_wdata, rf_wmask, dat[i], msk[i]); end
    end
    // With nothing granted the enable drops and the command fields hold
    idleCycle();
    e = expQ.pop_front();
    checks++; if (rf_we !== 1'b0 || rf_waddr !== 5'd9 || rf_wdata !== 32'h0BADBEEF || rf_wmask !== 4'b1111) begin errors++; $display("[TB] FAIL idle_hold got we=%b addr=%0d data=%h mask=%b want we=0 addr=9 data=0badbeef mask=1111", rf_we, rf_waddr, rf_wdata, rf_wmask); end
  endtask

  task automatic test_zero_reg();
    applyStimulus(1, 5'd0, 32'hFFFFFFFF, 2'b10, 0, 5'd0, 32'd0, 2'b00, 0, 5'd0);
    checks++; if (obsAluReady !== 1'b1) begin errors++; $display("[TB] FAIL zero_ready got %b want 1", obsAluReady); end
    e = expQ.pop_front();
    checks++; if (rf_we !== 1'b0) begin errors++; $display("[TB] FAIL zero_we got %b want 0", rf_we); end
  endtask

  task automatic test_scoreboard();
    applyStimulus(0, 5'd0, 32'd0, 2'b00, 0, 5'd0, 32'd0, 2'b00, 1, 5'd7);
    checks++; if (obsAllocOk !== 1'b1) begin errors++; $display("[TB] FAIL sb_alloc_free got %b want 1", obsAllocOk); end
    e = expQ.pop_front();
    issue_rd = 5'd7; issue_rs = 5'd7; issue_rt = 5'd8; issue_alloc = 1'b0;
    #1;
    checks++; if (alloc_ok !== 1'b0 || rs_busy !== 1'b1 || rt_busy !== busyM[8]) begin errors++; $display("[TB] FAIL sb_busy7 got ok=%b rs=%b rt=%b want ok=0 rs=1 rt=%b", alloc_ok, rs_busy, rt_busy, busyM[8]); end
    // Grant of rd=7 clears it; the bit must still read busy during that cycle
    issue_rs = 5'd7;
    applyStimulus(1, 5'd7, 32'h77, 2'b10, 0, 5'd0, 32'd0, 2'b00, 0, 5'd0);
    e = expQ.pop_front();
    checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd7) begin errors++; $display("[TB] FAIL sb_write7 got we=%b addr=%0d want we=1 addr=7", rf_we, rf_waddr); end
    checks++; if (rs_busy !== 1'b0 || busyM[7] !== 1'b0) begin errors++; $display("[TB] FAIL sb_clear7 got %b want 0", rs_busy); end
    // Allocation and grant of the same register together: allocation wins
    applyStimulus(1, 5'd7, 32'h78, 2'b10, 0, 5'd0, 32'd0, 2'b00, 1, 5'd7);
    checks++; if (obsAllocOk !== expAllocOk || obsAluReady !== 1'b1) begin errors++; $display("[TB] FAIL sb_same_cycle got ok=%b rdy=%b want ok=%b rdy=1", obsAllocOk, obsAluReady, expAllocOk); end
    e = expQ.pop_front();
    issue_alloc = 1'b0;
    #1;
    checks++; if (rs_busy !== 1'b1) begin errors++; $display("[TB] FAIL sb_set_wins got %b want 1", rs_busy); end
    // A refused allocation leaves the scoreboard untouched; rd=0 never goes busy
    applyStimulus(0, 5'd0, 32'd0, 2'b00, 0, 5'd0, 32'd0, 2'b00, 1, 5'd7);
    e = expQ.pop_front();
    checks++; if (obsAllocOk !== 1'b0) begin errors++; $display("[TB] FAIL sb_refuse got %b want 0", obsAllocOk); end
    applyStimulus(0, 5'd0, 32'd0, 2'b00, 0, 5'd0, 32'd0, 2'b00, 1, 5'd0);
    e = expQ.pop_front();
    issue_rt = 5'd0; issue_alloc = 1'b0;
    #1;
    checks++; if (rt_busy !== 1'b0) begin errors++; $display("[TB] FAIL sb_zero_busy got %b want 0", rt_busy); end
  endtask

  task automatic test_back_to_back();
    logic aV, mV;
    logic [4:0] aRd, mRd, aRdA;
    for (int i = 0; i < 24; i++) begin
      aV  = ($urandom_range(0, 3) != 0);
      mV  = ($urandom_range(0, 2) != 0);
      aRd = 5'($urandom_range(0, 31));
      mRd = 5'($urandom_range(1, 31));
      aRdA = 5'($urandom_range(0, 31));
      applyStimulus(aV, aRd, $urandom, 2'($urandom_range(0, 3)), mV, mRd, $urandom,
                    2'($urandom_range(0, 3)), $urandom_range(0, 1) == 1, aRdA);
      checks++; if (obsAluReady !== expAluReady || obsMemReady !== expMemReady || obsAllocOk !== expAllocOk) begin errors++; $display("[TB] FAIL b2b_ready%0d got alu=%b mem=%b ok=%b want alu=%b mem=%b ok=%b", i, obsAluReady, obsMemReady, obsAllocOk, expAluReady, expMemReady, expAllocOk); end
      e = expQ.pop_front();
      checks++; if (rf_we !== e.we || (e.chk && (rf_waddr !== e.addr || rf_wdata !== e.data || rf_wmask !== e.mask))) begin errors++; $display("[TB] FAIL b2b_write%0d got we=%b addr=%0d data=%h mask=%b want we=%b addr=%0d data=%h mask=%b", i, rf_we, rf_waddr, rf_wdata, rf_wmask, e.we, e.addr, e.data, e.mask); end
      issue_rs = 5'($urandom_range(0, 31));
      #1;
      checks++; if (rs_busy !== busyM[issue_rs]) begin errors++; $display("[TB] FAIL b2b_busy%0d reg %0d got %b want %b", i, issue_rs, rs_busy, busyM[issue_rs]); end
    end
  endtask

  task automatic test_async_reset();
    applyStimulus(1, 5'd5, 32'h55, 2'b10, 0, 5'd0, 32'd0, 2'b00, 1, 5'd20);
    e = expQ.pop_front();
    checks++; if (rf_we !== 1'b1) begin errors++; $display("[TB] FAIL areset_pre_we got %b want 1", rf_we); end
    issue_rs = 5'd20; issue_rt = 5'd5;
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (rf_we !== 1'b0 || alu_ready !== 1'b0) begin errors++; $display("[TB] FAIL areset_we got we=%b rdy=%b want 0", rf_we, alu_ready); end
    checks++; if (rs_busy !== 1'b0 || rf_waddr !== 5'd0) begin errors++; $display("[TB] FAIL areset_busy got busy=%b addr=%0d want 0", rs_busy, rf_waddr); end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    modelReset();
    idleCycle();
    e = expQ.pop_front();
    checks++; if (rf_we !== 1'b0) begin errors++; $display("[TB] FAIL areset_after got %b want 0", rf_we); end
  endtask

  initial begin
    modelReset();
    test_reset();
    test_alternation();
    test_byte_enables();
    test_zero_reg();
    test_scoreboard();
    test_back_to_back();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
